pwm_update_arbiter: RTL and testbench

- Shares the PWM duty-cycle / switching-frequency update path between two requesters.
  - Requester 0: host register port.
  - Requester 1: soft-start ramp engine.
- Arbitrates round-robin and drives the write-enable side of the PWM register-interface FIFOs.
- Tracks FIFO occupancy with shadow counters so no write is ever issued to a full FIFO.
- Sits between the requesters and the FIFO-based register interface; observes the same period-start strobe that pops those FIFOs.

---
 rtl/pwm_update_arbiter.sv | 136 +++++++++++++
 tb/tb_pwm_update_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_arbiter.sv
// Round-robin arbiter that merges host and soft-start updates into the PWM duty and
// frequency FIFOs, keeping a shadow occupancy count so a full FIFO is never written.
module pwm_update_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_r0_valid,
    input  logic [WIDTH-1:0] i_r0_duty,
    input  logic [WIDTH-1:0] i_r0_freq,
    input  logic             i_r0_duty_en,
    input  logic             i_r0_freq_en,
    output logic             o_r0_ready,
    input  logic             i_r1_valid,
    input  logic [WIDTH-1:0] i_r1_duty,
    input  logic [WIDTH-1:0] i_r1_freq,
    input  logic             i_r1_duty_en,
    input  logic             i_r1_freq_en,
    output logic             o_r1_ready,
    input  logic             i_period_start,
    output logic [WIDTH-1:0] o_duty_cycle,
    output logic             o_duty_cycle_we,
    output logic [WIDTH-1:0] o_switch_freq,
    output logic             o_switch_freq_we,
    output logic [CNT_W-1:0] o_duty_level,
    output logic [CNT_W-1:0] o_freq_level,
    output logic             o_last_grant
);

    localparam logic [CNT_W:0] LP_DEPTH = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0] r_duty_level;
    logic [CNT_W-1:0] r_freq_level;
    logic             r_duty_we_p1;
    logic             r_freq_we_p1;
    logic [WIDTH-1:0] r_duty_p1;
    logic [WIDTH-1:0] r_freq_p1;
    logic             r_last_grant;

    logic             w_pop_d;
    logic             w_pop_f;
    logic [CNT_W:0]   w_duty_sum;
    logic [CNT_W:0]   w_freq_sum;
    logic             w_space_d;
    logic             w_space_f;
    logic             w_elig0;
    logic             w_elig1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_gnt_any;
    logic             w_sel_duty_en;
    logic             w_sel_freq_en;
    logic [WIDTH-1:0] w_sel_duty;
    logic [WIDTH-1:0] w_sel_freq;

    assign w_pop_d = i_period_start && (r_duty_level != '0);
    assign w_pop_f = i_period_start && (r_freq_level != '0);

    // Space is judged against the level plus the write already in flight; a same-cycle pop is ignored.
    assign w_duty_sum = {1'b0, r_duty_level} + {{CNT_W{1'b0}}, r_duty_we_p1};
    assign w_freq_sum = {1'b0, r_freq_level} + {{CNT_W{1'b0}}, r_freq_we_p1};
    assign w_space_d  = (w_duty_sum < LP_DEPTH);
    assign w_space_f  = (w_freq_sum < LP_DEPTH);

    assign w_elig0 = i_r0_valid && (!i_r0_duty_en || w_space_d) && (!i_r0_freq_en || w_space_f);
    assign w_elig1 = i_r1_valid && (!i_r1_duty_en || w_space_d) && (!i_r1_freq_en || w_space_f);

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_gnt0 = r_last_grant;
            w_gnt1 = !r_last_grant;
        end else begin
            w_gnt0 = w_elig0;
            w_gnt1 = w_elig1;
        end
    end

    assign w_gnt_any     = w_gnt0 || w_gnt1;
    assign w_sel_duty_en = w_gnt1 ? i_r1_duty_en : i_r0_duty_en;
    assign w_sel_freq_en = w_gnt1 ? i_r1_freq_en : i_r0_freq_en;
    assign w_sel_duty    = w_gnt1 ? i_r1_duty    : i_r0_duty;
    assign w_sel_freq    = w_gnt1 ? i_r1_freq    : i_r0_freq;

    assign o_r0_ready = w_gnt0;
    assign o_r1_ready = w_gnt1;

    // Write stage: grant in one cycle, FIFO write enables the next.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_duty_we_p1 <= 1'b0;
            r_freq_we_p1 <= 1'b0;
            r_duty_p1    <= '0;
            r_freq_p1    <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_duty_we_p1 <= w_gnt_any && w_sel_duty_en;
            r_freq_we_p1 <= w_gnt_any && w_sel_freq_en;
            if (w_gnt_any) begin
                r_duty_p1    <= w_sel_duty;
                r_freq_p1    <= w_sel_freq;
                r_last_grant <= w_gnt1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_duty_level <= '0;
            r_freq_level <= '0;
        end else begin
            if (r_duty_we_p1 && !w_pop_d) begin
                r_duty_level <= r_duty_level + CNT_W'(1);
            end else if (!r_duty_we_p1 && w_pop_d) begin
                r_duty_level <= r_duty_level - CNT_W'(1);
            end
            if (r_freq_we_p1 && !w_pop_f) begin
                r_freq_level <= r_freq_level + CNT_W'(1);
            end else if (!r_freq_we_p1 && w_pop_f) begin
                r_freq_level <= r_freq_level - CNT_W'(1);
            end
        end
    end

    assign o_duty_cycle     = r_duty_p1;
    assign o_duty_cycle_we  = r_duty_we_p1;
    assign o_switch_freq    = r_freq_p1;
    assign o_switch_freq_we = r_freq_we_p1;
    assign o_duty_level     = r_duty_level;
    assign o_freq_level     = r_freq_level;
    assign o_last_grant     = r_last_grant;

endmodule

// File: tb/tb_pwm_update_arbiter.sv
// Self-checking bench for pwm_update_arbiter: directed scenarios then random traffic,
// compared against a queue-based model of the two downstream FIFOs and the arbitration rules.
module tb_pwm_update_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             i_r0_valid, i_r0_duty_en, i_r0_freq_en, o_r0_ready;
    logic [WIDTH-1:0] i_r0_duty, i_r0_freq;
    logic             i_r1_valid, i_r1_duty_en, i_r1_freq_en, o_r1_ready;
    logic [WIDTH-1:0] i_r1_duty, i_r1_freq;
    logic             i_period_start;
    logic [WIDTH-1:0] o_duty_cycle, o_switch_freq;
    logic             o_duty_cycle_we, o_switch_freq_we, o_last_grant;
    logic [CNT_W-1:0] o_duty_level, o_freq_level;

    always #5 clk = ~clk;

    pwm_update_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_valid(i_r0_valid), .i_r0_duty(i_r0_duty), .i_r0_freq(i_r0_freq),
        .i_r0_duty_en(i_r0_duty_en), .i_r0_freq_en(i_r0_freq_en), .o_r0_ready(o_r0_ready),
        .i_r1_valid(i_r1_valid), .i_r1_duty(i_r1_duty), .i_r1_freq(i_r1_freq),
        .i_r1_duty_en(i_r1_duty_en), .i_r1_freq_en(i_r1_freq_en), .o_r1_ready(o_r1_ready),
        .i_period_start(i_period_start),
        .o_duty_cycle(o_duty_cycle), .o_duty_cycle_we(o_duty_cycle_we),
        .o_switch_freq(o_switch_freq), .o_switch_freq_we(o_switch_freq_we),
        .o_duty_level(o_duty_level), .o_freq_level(o_freq_level),
        .o_last_grant(o_last_grant)
    );

    int errors = 0;
    int checks = 0;

    // Requester-side state: a pending request is held stable until accepted.
    bit         rv[2];
    logic [7:0] rd[2];
    logic [7:0] rf[2];
    bit         rde[2];
    bit         rfe[2];
    bit         refill;
    bit         ps;
    bit         rst_in;

    // Reference model: FIFO contents as queues plus the in-flight write.
    logic [7:0] qd[$];
    logic [7:0] qf[$];
    bit         m_we_d, m_we_f, m_last;
    logic [7:0] m_duty, m_freq;

    bit dut_rdy[2];
    int dut_grants;
    int dut_r1_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit sd, sf, e0, e1, g0, g1;
        int k;
        @(negedge clk);
        if (rst_in) begin
            rv[0] = 1'b0;
            rv[1] = 1'b0;
        end
        rst            = rst_in;
        i_period_start = ps;
        i_r0_valid = rv[0]; i_r0_duty = rd[0]; i_r0_freq = rf[0];
        i_r0_duty_en = rde[0]; i_r0_freq_en = rfe[0];
        i_r1_valid = rv[1]; i_r1_duty = rd[1]; i_r1_freq = rf[1];
        i_r1_duty_en = rde[1]; i_r1_freq_en = rfe[1];
        #1;
        sd = (qd.size() + int'(m_we_d)) < DEPTH;
        sf = (qf.size() + int'(m_we_f)) < DEPTH;
        e0 = rv[0] && (!rde[0] || sd) && (!rfe[0] || sf);
        e1 = rv[1] && (!rde[1] || sd) && (!rfe[1] || sf);
        g0 = e0 && (!e1 || m_last);
        g1 = e1 && (!e0 || !m_last);
        chk("ready0", o_r0_ready, g0);
        chk("ready1", o_r1_ready, g1);
        dut_rdy[0] = o_r0_ready;
        dut_rdy[1] = o_r1_ready;
        if (o_r0_ready || o_r1_ready) dut_grants++;
        if (o_r1_ready) dut_r1_cnt++;
        @(posedge clk);
        #1;
        if (rst_in) begin
            qd.delete(); qf.delete();
            m_we_d = 0; m_we_f = 0; m_last = 1; m_duty = '0; m_freq = '0;
        end else begin
            if (ps && qd.size() != 0) void'(qd.pop_front());
            if (ps && qf.size() != 0) void'(qf.pop_front());
            if (m_we_d) qd.push_back(m_duty);
            if (m_we_f) qf.push_back(m_freq);
            if (g0 || g1) begin
                k = g1 ? 1 : 0;
                m_we_d = rde[k]; m_we_f = rfe[k];
                m_duty = rd[k];  m_freq = rf[k];
                m_last = (k == 1);
                rv[k]  = 1'b0;
            end else begin
                m_we_d = 0; m_we_f = 0;
            end
        end
        if (refill) begin
            for (int j = 0; j < 2; j++) begin
                if (!rv[j]) begin
                    rv[j] = 1'b1;
                    rd[j] = 8'($urandom);
                    rf[j] = 8'($urandom);
                end
            end
        end
        chk("duty_we", o_duty_cycle_we, m_we_d);
        chk("freq_we", o_switch_freq_we, m_we_f);
        chk("duty_level", o_duty_level, qd.size());
        chk("freq_level", o_freq_level, qf.size());
        chk("last_grant", o_last_grant, m_last);
        if (m_we_d) chk("duty_data", o_duty_cycle, m_duty);
        if (m_we_f) chk("freq_data", o_switch_freq, m_freq);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        refill = 1'b0;
        ps     = 1'b0;
        cycle();
        rst_in = 1'b0;
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic [7:0] f,
                        input bit de, input bit fe);
        int n;
        rv[k] = 1'b1; rd[k] = d; rf[k] = f; rde[k] = de; rfe[k] = fe;
        n = 0;
        dut_rdy[k] = 1'b0;
        while (!dut_rdy[k] && n < 20) begin
            cycle();
            n++;
        end
        chk($sformatf("send_acc_r%0d", k), dut_rdy[k], 1'b1);
        rv[k] = 1'b0;
    endtask

    initial begin
        int g_before, r1_before;
        rst_in = 1'b1; refill = 1'b0; ps = 1'b0;
        for (int j = 0; j < 2; j++) begin
            rv[j] = 0; rd[j] = '0; rf[j] = '0; rde[j] = 0; rfe[j] = 0;
        end
        m_we_d = 0; m_we_f = 0; m_last = 1; m_duty = '0; m_freq = '0;
        dut_grants = 0; dut_r1_cnt = 0;

        // Reset state
        do_reset();
        chk("rst_duty_data", o_duty_cycle, 8'h00);
        chk("rst_freq_data", o_switch_freq, 8'h00);
        chk("rst_last", o_last_grant, 1'b1);

        // Single combined update from r0
        send(0, 8'h40, 8'h10, 1, 1);
        chk("t1_duty_we", o_duty_cycle_we, 1'b1);
        chk("t1_duty", o_duty_cycle, 8'h40);
        chk("t1_freq", o_switch_freq, 8'h10);
        cycle();
        chk("t1_dlevel", o_duty_level, 1);
        chk("t1_flevel", o_freq_level, 1);

        // Continuous contention, duty-only, until the duty FIFO is full
        do_reset();
        rde[0] = 1; rfe[0] = 0; rde[1] = 1; rfe[1] = 0;
        rv[0] = 1; rv[1] = 1; rd[0] = 8'h11; rd[1] = 8'h22;
        refill = 1'b1;
        dut_grants = 0;
        for (int i = 0; i < 12; i++) cycle();
        chk("fill_grants", dut_grants, 8);
        chk("fill_level", o_duty_level, 8);
        ps = 1'b1;
        cycle();
        ps = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("refill_grants", dut_grants, 9);
        chk("refill_level", o_duty_level, 8);
        refill = 1'b0;

        // Full frequency FIFO blocks an atomic duty+freq request only
        do_reset();
        for (int i = 0; i < 3; i++) send(0, 8'(i), 8'(i + 8'h80), 1, 1);
        for (int i = 0; i < 5; i++) send(0, 8'h00, 8'(i + 8'h90), 0, 1);
        cycle();
        chk("blk_pre_dlevel", o_duty_level, 3);
        chk("blk_pre_flevel", o_freq_level, 8);
        r1_before = dut_r1_cnt;
        rv[1] = 1; rd[1] = 8'hA1; rf[1] = 8'hA2; rde[1] = 1; rfe[1] = 1;
        rv[0] = 1; rd[0] = 8'hB1; rf[0] = 8'hB2; rde[0] = 1; rfe[0] = 0;
        for (int i = 0; i < 4; i++) cycle();
        chk("blk_r1_grants", dut_r1_cnt - r1_before, 0);
        chk("blk_flevel", o_freq_level, 8);
        chk("blk_dlevel", o_duty_level, 4);

        // Period start on empty FIFOs, and coinciding with a write
        do_reset();
        ps = 1'b1;
        cycle();
        ps = 1'b0;
        chk("empty_pop_d", o_duty_level, 0);
        chk("empty_pop_f", o_freq_level, 0);
        for (int i = 0; i < 5; i++) send(0, 8'(8'h30 + i), 8'h00, 1, 0);
        cycle();
        chk("pre_coin_level", o_duty_level, 5);
        send(1, 8'h5A, 8'h00, 1, 0);
        ps = 1'b1;
        cycle();
        ps = 1'b0;
        chk("coin_level", o_duty_level, 5);

        // Reset while a write is pending
        do_reset();
        for (int i = 0; i < 4; i++) send(0, 8'h01, 8'h02, 1, 1);
        for (int i = 0; i < 2; i++) send(1, 8'h00, 8'h03, 0, 1);
        cycle();
        send(0, 8'h07, 8'h08, 1, 1);
        chk("mid_dlevel", o_duty_level, 4);
        chk("mid_flevel", o_freq_level, 6);
        do_reset();
        chk("mid_rst_we_d", o_duty_cycle_we, 1'b0);
        chk("mid_rst_we_f", o_switch_freq_we, 1'b0);
        chk("mid_rst_dlevel", o_duty_level, 0);
        chk("mid_rst_last", o_last_grant, 1'b1);
        rv[0] = 1; rd[0] = 8'hC0; rde[0] = 1; rfe[0] = 0;
        rv[1] = 1; rd[1] = 8'hC1; rde[1] = 1; rfe[1] = 0;
        cycle();
        chk("post_rst_first", o_last_grant, 1'b0);
        cycle();
        chk("post_rst_second", o_last_grant, 1'b1);

        // Request with no enables still rotates the grant
        cycle();
        r1_before = dut_r1_cnt;
        send(1, 8'hEE, 8'hEF, 0, 0);
        chk("noen_r1_ready", dut_r1_cnt - r1_before, 1);
        chk("noen_we_d", o_duty_cycle_we, 1'b0);
        chk("noen_we_f", o_switch_freq_we, 1'b0);
        chk("noen_last", o_last_grant, 1'b1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (!rv[j] && $urandom_range(0, 1) == 0) begin
                    rv[j]  = 1'b1;
                    rd[j]  = 8'($urandom);
                    rf[j]  = 8'($urandom);
                    rde[j] = 1'($urandom_range(0, 1));
                    rfe[j] = 1'($urandom_range(0, 1));
                end
            end
            ps     = ($urandom_range(0, 3) == 0);
            rst_in = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
